// File: rtl/ntt_addr_gen_if.sv
// Butterfly op stream from the NTT address sequencer to the poly-RAM datapath.
// The stream uses a valid/ready handshake.
interface ntt_addr_gen_if;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_addr_a;
    logic [7:0]  op_addr_b;
    logic [11:0] op_zeta;
    logic [2:0]  op_layer;
    logic        op_last;

    modport master (
        output op_valid,
        output op_addr_a,
        output op_addr_b,
        output op_zeta,
        output op_layer,
        output op_last,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_addr_a,
        input  op_addr_b,
        input  op_zeta,
        input  op_layer,
        input  op_last,
        output op_ready
    );
endinterface

// File: rtl/ntt_addr_gen.sv
// ML-KEM NTT/INTT sequencer: walks 7 layers of 128 butterflies and emits one
// (addr_a, addr_b, zeta) op per handshake. It also emits a done pulse after the last op.
module ntt_addr_gen (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    ntt_addr_gen_if.master    op
);

    localparam int unsigned LogN    = 8;
    localparam int unsigned NLayers = 7;

    // 17^brv7(i) mod 3329
    localparam logic [11:0] ZetaNttTable [128] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    typedef struct packed {
        logic [LogN-1:0] a;
        logic [LogN-1:0] b;
        logic [6:0]      zidx;
    } op_t;

    // sh = log2(len): forward len = 128>>l, inverse len = 2<<l.
    function automatic op_t calc_op(input logic inv, input logic [2:0] l, input logic [6:0] bf);
        logic [2:0]      sh;
        logic [6:0]      mask;
        logic [6:0]      g;
        logic [6:0]      off;
        logic [LogN-1:0] a;
        op_t             r;
        sh     = inv ? (l + 3'd1) : (3'd7 - l);
        mask   = 7'((8'd1 << sh) - 8'd1);
        g      = bf >> sh;
        off    = bf & mask;
        a      = (8'(g) << (4'(sh) + 4'd1)) + 8'(off);
        r.a    = a;
        r.b    = a + (8'd1 << sh);
        r.zidx = inv ? 7'((8'd128 >> l) - 8'd1 - 8'(g)) : 7'((8'd1 << l) + 8'(g));
        return r;
    endfunction

    state_e          state_q;
    logic            mode_q;
    logic [2:0]      layer_q;
    logic [6:0]      bfly_q;
    logic            busy_q;
    logic            done_q;
    logic            valid_q;
    logic            last_q;
    logic [LogN-1:0] addr_a_q;
    logic [LogN-1:0] addr_b_q;
    logic [11:0]     zeta_q;
    logic [2:0]      op_layer_q;

    logic [2:0]      nxt_layer;
    logic [6:0]      nxt_bfly;
    op_t             first_op;
    op_t             adv_op;
    logic            handshake;

    always_comb begin
        nxt_bfly  = bfly_q + 7'd1;
        nxt_layer = (bfly_q == 7'd127) ? (layer_q + 3'd1) : layer_q;
        first_op  = calc_op(mode, 3'd0, 7'd0);
        adv_op    = calc_op(mode_q, nxt_layer, nxt_bfly);
        handshake = valid_q && op.op_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 1'b0;
            layer_q    <= 3'd0;
            bfly_q     <= 7'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            zeta_q     <= 12'd0;
            op_layer_q <= 3'd0;
        end else if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= StRun;
                        mode_q     <= mode;
                        layer_q    <= 3'd0;
                        bfly_q     <= 7'd0;
                        busy_q     <= 1'b1;
                        valid_q    <= 1'b1;
                        last_q     <= 1'b0;
                        addr_a_q   <= first_op.a;
                        addr_b_q   <= first_op.b;
                        zeta_q     <= ZetaNttTable[first_op.zidx];
                        op_layer_q <= 3'd0;
                    end
                end
                StRun: begin
                    if (handshake) begin
                        if (last_q) begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            layer_q    <= nxt_layer;
                            bfly_q     <= nxt_bfly;
                            addr_a_q   <= adv_op.a;
                            addr_b_q   <= adv_op.b;
                            zeta_q     <= ZetaNttTable[adv_op.zidx];
                            op_layer_q <= nxt_layer;
                            last_q     <= (nxt_layer == 3'(NLayers - 1)) && (nxt_bfly == 7'd127);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign op.op_valid  = valid_q;
    assign op.op_addr_a = addr_a_q;
    assign op.op_addr_b = addr_b_q;
    assign op.op_zeta   = zeta_q;
    assign op.op_layer  = op_layer_q;
    assign op.op_last   = last_q;

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed bench for ntt_addr_gen: golden op sequence built from the FIPS 203 loop nest
// with zetas computed as 17^brv7(k) mod 3329, plus hand-computed vector table.
module tb_ntt_addr_gen;

    logic clk;
    logic rst_n;
    logic start;
    logic mode;
    logic abort;
    logic busy;
    logic done;

    ntt_addr_gen_if op_if ();

    ntt_addr_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .op    (op_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    int gold_a [2][896];
    int gold_b [2][896];
    int gold_z [2][896];
    int gold_l [2][896];
    int cap_a  [2][896];
    int cap_b  [2][896];
    int cap_z  [2][896];
    int cap_l  [2][896];
    int cap_t  [2][896];

    typedef struct {
        bit    m;
        int    idx;
        int    a;
        int    b;
        int    z;
        int    layer;
        int    last;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int zeta_of(input int k);
        int br;
        int r;
        br = 0;
        r  = 1;
        for (int i = 0; i < 7; i++) br = br | (((k >> i) & 1) << (6 - i));
        for (int i = 0; i < br; i++) r = (r * 17) % 3329;
        return r;
    endfunction

    task automatic build_golden();
        int idx;
        int k;
        int len;
        int z;
        idx = 0;
        k   = 1;
        for (int l = 0; l < 7; l++) begin
            len = 128 >> l;
            for (int s = 0; s < 256; s += 2 * len) begin
                z = zeta_of(k);
                k++;
                for (int j = s; j < s + len; j++) begin
                    gold_a[0][idx] = j;
                    gold_b[0][idx] = j + len;
                    gold_z[0][idx] = z;
                    gold_l[0][idx] = l;
                    idx++;
                end
            end
        end
        idx = 0;
        k   = 127;
        for (int l = 0; l < 7; l++) begin
            len = 2 << l;
            for (int s = 0; s < 256; s += 2 * len) begin
                z = zeta_of(k);
                k--;
                for (int j = s; j < s + len; j++) begin
                    gold_a[1][idx] = j;
                    gold_b[1][idx] = j + len;
                    gold_z[1][idx] = z;
                    gold_l[1][idx] = l;
                    idx++;
                end
            end
        end
    endtask

    task automatic run(input bit m, input int pct, input bit inj_busy, input bit inj_done,
                       input string tag);
        int          n;
        int          mism;
        int          stall_err;
        int          bad_hits;
        int          cyc;
        bit          fin;
        int          hits[256];
        logic        pv;
        logic        pr;
        logic [7:0]  pa;
        logic [7:0]  pb;
        logic [11:0] pz;
        logic [2:0]  pl;
        logic        plst;
        n = 0; mism = 0; stall_err = 0; bad_hits = 0; cyc = 0; fin = 0;
        pv = 0; pr = 0; pa = 0; pb = 0; pz = 0; pl = 0; plst = 0;
        for (int i = 0; i < 256; i++) hits[i] = 0;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        check({tag, "_first_valid"}, 32'(op_if.op_valid), 32'd1);
        while (!fin && cyc < 10000) begin
            if (pv && !pr) begin
                if (op_if.op_valid !== 1'b1 || op_if.op_addr_a !== pa || op_if.op_addr_b !== pb ||
                    op_if.op_zeta !== pz || op_if.op_layer !== pl || op_if.op_last !== plst)
                    stall_err++;
            end
            if (done === 1'b1) begin
                fin = 1;
            end else begin
                if (inj_busy && cyc == 100) begin
                    start = 1'b1;
                    mode  = ~m;
                end else begin
                    start = 1'b0;
                end
                op_if.op_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
                if (op_if.op_valid === 1'b1 && op_if.op_ready === 1'b1) begin
                    if (n < 896) begin
                        if (int'(op_if.op_addr_a) != gold_a[m][n] ||
                            int'(op_if.op_addr_b) != gold_b[m][n] ||
                            int'(op_if.op_zeta) != gold_z[m][n] ||
                            int'(op_if.op_layer) != gold_l[m][n] ||
                            op_if.op_last !== (n == 895))
                            mism++;
                        cap_a[m][n] = int'(op_if.op_addr_a);
                        cap_b[m][n] = int'(op_if.op_addr_b);
                        cap_z[m][n] = int'(op_if.op_zeta);
                        cap_l[m][n] = int'(op_if.op_layer);
                        cap_t[m][n] = int'(op_if.op_last);
                    end else begin
                        mism++;
                    end
                    hits[op_if.op_addr_a]++;
                    hits[op_if.op_addr_b]++;
                    n++;
                end
                pv = op_if.op_valid; pr = op_if.op_ready;
                pa = op_if.op_addr_a; pb = op_if.op_addr_b; pz = op_if.op_zeta;
                pl = op_if.op_layer; plst = op_if.op_last;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 256; i++) if (hits[i] != 7) bad_hits++;
        check({tag, "_done_seen"}, 32'(fin), 32'd1);
        check({tag, "_handshakes"}, 32'(n), 32'd896);
        check({tag, "_sequence_mismatches"}, 32'(mism), 32'd0);
        check({tag, "_stall_unstable"}, 32'(stall_err), 32'd0);
        check({tag, "_index_hit_errors"}, 32'(bad_hits), 32'd0);
        check({tag, "_valid_in_done"}, 32'(op_if.op_valid), 32'd0);
        if (pct >= 100) check({tag, "_cycles_to_done"}, 32'(cyc), 32'd896);
        if (inj_done) begin
            start = 1'b1;
            mode  = 1'b1;
            @(negedge clk);
            check({tag, "_start_in_done_ignored"}, 32'(op_if.op_valid), 32'd0);
            check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
            @(negedge clk);
            start = 1'b0;
            check({tag, "_start_after_done_valid"}, 32'(op_if.op_valid), 32'd1);
            check({tag, "_start_after_done_inv_b"}, 32'(op_if.op_addr_b), 32'd2);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check({tag, "_abort_cleanup"}, 32'(op_if.op_valid), 32'd0);
        end else begin
            @(negedge clk);
            check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
        op_if.op_ready = 1'b0;
    endtask

    initial begin
        int n;
        int cyc;
        int dones;
        rst_n          = 1'b0;
        start          = 1'b0;
        mode           = 1'b0;
        abort          = 1'b0;
        op_if.op_ready = 1'b0;
        build_golden();

        vecs[0]  = '{m: 0, idx: 0,   a: 0,   b: 128, z: 1729, layer: 0, last: 0};
        vecs[1]  = '{m: 0, idx: 1,   a: 1,   b: 129, z: 1729, layer: 0, last: 0};
        vecs[2]  = '{m: 0, idx: 127, a: 127, b: 255, z: 1729, layer: 0, last: 0};
        vecs[3]  = '{m: 0, idx: 128, a: 0,   b: 64,  z: 2580, layer: 1, last: 0};
        vecs[4]  = '{m: 0, idx: 192, a: 128, b: 192, z: 3289, layer: 1, last: 0};
        vecs[5]  = '{m: 0, idx: 895, a: 253, b: 255, z: 2154, layer: 6, last: 1};
        vecs[6]  = '{m: 1, idx: 0,   a: 0,   b: 2,   z: 2154, layer: 0, last: 0};
        vecs[7]  = '{m: 1, idx: 1,   a: 1,   b: 3,   z: 2154, layer: 0, last: 0};
        vecs[8]  = '{m: 1, idx: 2,   a: 4,   b: 6,   z: 885,  layer: 0, last: 0};
        vecs[9]  = '{m: 1, idx: 128, a: 0,   b: 4,   z: 910,  layer: 1, last: 0};
        vecs[10] = '{m: 1, idx: 768, a: 0,   b: 128, z: 1729, layer: 6, last: 0};
        vecs[11] = '{m: 1, idx: 895, a: 127, b: 255, z: 1729, layer: 6, last: 1};

        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_valid", 32'(op_if.op_valid), 32'd0);
        check("reset_last", 32'(op_if.op_last), 32'd0);
        check("reset_addr_a", 32'(op_if.op_addr_a), 32'd0);
        check("reset_addr_b", 32'(op_if.op_addr_b), 32'd0);
        check("reset_zeta", 32'(op_if.op_zeta), 32'd0);
        check("reset_layer", 32'(op_if.op_layer), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ready with nothing valid must not start anything.
        op_if.op_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_valid", 32'(op_if.op_valid), 32'd0);
        check("idle_ready_busy", 32'(busy), 32'd0);
        check("idle_ready_done", 32'(done), 32'd0);
        op_if.op_ready = 1'b0;

        run(1'b0, 100, 1'b0, 1'b0, "fwd");
        run(1'b1, 100, 1'b0, 1'b0, "inv");

        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d_addr_a", i), 32'(cap_a[vecs[i].m][vecs[i].idx]), 32'(vecs[i].a));
            check($sformatf("vec%0d_addr_b", i), 32'(cap_b[vecs[i].m][vecs[i].idx]), 32'(vecs[i].b));
            check($sformatf("vec%0d_zeta", i), 32'(cap_z[vecs[i].m][vecs[i].idx]), 32'(vecs[i].z));
            check($sformatf("vec%0d_layer", i), 32'(cap_l[vecs[i].m][vecs[i].idx]),
                  32'(vecs[i].layer));
            check($sformatf("vec%0d_last", i), 32'(cap_t[vecs[i].m][vecs[i].idx]),
                  32'(vecs[i].last));
        end

        run(1'b0, 30, 1'b1, 1'b0, "fwd_bp_busy_start");
        run(1'b1, 30, 1'b0, 1'b0, "inv_bp");
        run(1'b0, 100, 1'b0, 1'b1, "fwd_start_in_done");

        // Abort with op300 on the bus; abort also overrides a pending handshake.
        @(negedge clk);
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        op_if.op_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 300 && cyc < 2000) begin
            if (op_if.op_valid === 1'b1) n++;
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_op300", 32'(n), 32'd300);
        check("abort_op300_addr_a", 32'(op_if.op_addr_a), 32'(gold_a[0][300]));
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_valid", 32'(op_if.op_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1 || op_if.op_valid === 1'b1) dones++;
        end
        check("abort_quiet_after", 32'(dones), 32'd0);
        op_if.op_ready = 1'b0;
        run(1'b0, 100, 1'b0, 1'b0, "abort_replay");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        op_if.op_ready = 1'b1;
        repeat (50) @(negedge clk);
        check("midrun_valid_before_reset", 32'(op_if.op_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(op_if.op_valid), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_last", 32'(op_if.op_last), 32'd0);
        op_if.op_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b1, 30, 1'b0, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
